// File: rtl/gpio_bus_if.sv
// Register-access bus between a core-side master and the GPIO controller.
// One access per cycle with bus_en; the response returns one cycle later.
interface gpio_bus_if;
  logic        bus_en;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_error;

  modport master (
    output bus_en, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready, bus_error
  );

  modport slave (
    input  bus_en, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready, bus_error
  );
endinterface

// File: rtl/gpio_ctrl.sv
// Multi-channel GPIO controller: OUT/DIR/IN registers, SET/CLR shortcuts,
// synchronised inputs with rise/fall edge interrupts and a registered irq.
module gpio_ctrl #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  gpio_bus_if.slave                 bus,
  input  logic [CHANNELS*WIDTH-1:0] gpio_i,
  output logic [CHANNELS*WIDTH-1:0] gpio_o,
  output logic [CHANNELS*WIDTH-1:0] gpio_oe,
  output logic                      irq
);

  logic [CHANNELS-1:0][WIDTH-1:0]    r_out;
  logic [CHANNELS-1:0][WIDTH-1:0]    r_dir;
  logic [CHANNELS-1:0][WIDTH-1:0]    r_rise;
  logic [CHANNELS-1:0][WIDTH-1:0]    r_fall;
  logic [CHANNELS-1:0][WIDTH-1:0]    r_pend;
  logic [SYNC_STAGES-1:0][CHANNELS*WIDTH-1:0] r_sync;
  logic [CHANNELS*WIDTH-1:0]         r_dly;
  logic                              r_ready;
  logic                              r_error;
  logic [31:0]                       r_rdata;
  logic                              r_irq;

  logic [2:0]                        w_ch;
  logic [2:0]                        w_off;
  logic                              w_ch_ok;
  logic                              w_err;
  logic                              w_wr;
  logic                              w_rd;
  logic [WIDTH-1:0]                  w_wd;
  logic [CHANNELS*WIDTH-1:0]         w_last;
  logic [CHANNELS*WIDTH-1:0]         w_set;
  logic [CHANNELS-1:0][WIDTH-1:0]    w_pclr;
  logic [CHANNELS-1:0][31:0]         w_word;
  logic [31:0]                       w_rdata;

  assign w_ch    = bus.bus_addr[7:5];
  assign w_off   = bus.bus_addr[4:2];
  assign w_ch_ok = (32'(w_ch) < CHANNELS);
  assign w_err   = (bus.bus_addr[1:0] != 2'b00) || !w_ch_ok ||
                   (bus.bus_we && (w_off == 3'd2));
  assign w_wr    = bus.bus_en && bus.bus_we && !w_err;
  assign w_rd    = bus.bus_en && !bus.bus_we && !w_err;
  assign w_wd    = bus.bus_wdata[WIDTH-1:0];

  // Edge qualification: last sync stage against its one-cycle-delayed copy.
  assign w_last  = r_sync[SYNC_STAGES-1];
  assign w_set   = (w_last & ~r_dly & r_rise) | (~w_last & r_dly & r_fall);

  assign gpio_o  = r_out;
  assign gpio_oe = r_dir;
  assign irq     = r_irq;

  assign bus.bus_ready = r_ready;
  assign bus.bus_error = r_error;
  assign bus.bus_rdata = r_rdata;

  // Per-channel read word and pending-clear mask for the current access.
  always_comb begin
    w_rdata = 32'd0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_word[c] = 32'd0;
      case (w_off)
        3'd0:    w_word[c][WIDTH-1:0] = r_out[c];
        3'd1:    w_word[c][WIDTH-1:0] = r_dir[c];
        3'd2:    w_word[c][WIDTH-1:0] = w_last[c*WIDTH +: WIDTH];
        3'd3:    w_word[c][WIDTH-1:0] = r_rise[c];
        3'd4:    w_word[c][WIDTH-1:0] = r_fall[c];
        3'd5:    w_word[c][WIDTH-1:0] = r_pend[c];
        default: w_word[c] = 32'd0;
      endcase
      w_rdata = w_rdata | ((w_ch == c[2:0]) ? w_word[c] : 32'd0);
      w_pclr[c] = (w_wr && (w_ch == c[2:0]) && (w_off == 3'd5)) ? w_wd : {WIDTH{1'b0}};
    end
  end

  // Register file, pending bits and interrupt; a set edge beats a W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr && (w_ch == c[2:0])) begin
          case (w_off)
            3'd0:    r_out[c]  <= w_wd;
            3'd1:    r_dir[c]  <= w_wd;
            3'd3:    r_rise[c] <= w_wd;
            3'd4:    r_fall[c] <= w_wd;
            3'd6:    r_out[c]  <= r_out[c] | w_wd;
            3'd7:    r_out[c]  <= r_out[c] & ~w_wd;
            default: r_out[c]  <= r_out[c];
          endcase
        end
        r_pend[c] <= (r_pend[c] & ~w_pclr[c]) | w_set[c*WIDTH +: WIDTH];
      end
      r_irq <= |r_pend;
    end
  end

  // Input synchroniser chain and edge-detect delay stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_dly  <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_dly <= w_last;
    end
  end

  // Fixed one-cycle bus response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= bus.bus_en;
      r_error <= bus.bus_en && w_err;
      r_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed, table-driven bench for gpio_ctrl (CHANNELS=2, WIDTH=32, SYNC_STAGES=2).
module tb_gpio_ctrl;
  logic        clk;
  logic        reset;
  logic [63:0] gpio_i;
  logic [63:0] gpio_o;
  logic [63:0] gpio_oe;
  logic        irq;
  int          total;
  int          bad;

  gpio_bus_if bus_if ();

  gpio_ctrl #(.CHANNELS(2), .WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic acc(input logic we, input logic [7:0] a, input logic [31:0] d);
    bus_if.bus_en    = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus_if.bus_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] zero_addrs[10];
    total = 0;
    bad   = 0;
    reset = 1'b1;
    gpio_i = 64'd0;
    bus_if.bus_en    = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = 8'h00;
    bus_if.bus_wdata = 32'd0;

    vecs[0]  = '{1'b1, 8'h04, 32'h0000FFFF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 32'h12345678, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 32'h00000000, 32'h12345678, 1'b0};
    vecs[3]  = '{1'b0, 8'h04, 32'h00000000, 32'h0000FFFF, 1'b0};
    vecs[4]  = '{1'b1, 8'h20, 32'h00000000, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b1, 8'h38, 32'h0000000F, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 32'h00000003, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 8'h20, 32'h00000000, 32'h0000000C, 1'b0};
    vecs[8]  = '{1'b0, 8'h38, 32'h00000000, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 8'h40, 32'h00000000, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 8'h02, 32'h00000000, 32'h00000000, 1'b1};
    vecs[11] = '{1'b1, 8'h08, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 32'h00000000, 32'h12345678, 1'b0};
    vecs[13] = '{1'b0, 8'hE0, 32'h00000000, 32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 8'h41, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[15] = '{1'b0, 8'h08, 32'h00000000, 32'hA5A50000, 1'b0};
    vecs[16] = '{1'b0, 8'h28, 32'h00000000, 32'h00000000, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    check("rst_rdata", bus_if.bus_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_oe", gpio_oe[31:0] | gpio_oe[63:32], 32'd0);
    check("rst_o", gpio_o[31:0] | gpio_o[63:32], 32'd0);
    reset = 1'b0;
    gpio_i[31:0] = 32'hA5A50000;

    for (int i = 0; i < 17; i++) begin
      acc(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_ready", i), {31'd0, bus_if.bus_ready}, 32'd1);
      check($sformatf("v%0d_err", i), {31'd0, bus_if.bus_error}, {31'd0, vecs[i].err});
      if (!vecs[i].we || vecs[i].err) begin
        check($sformatf("v%0d_rdata", i), bus_if.bus_rdata, vecs[i].rdata);
      end
    end
    idle(1);
    check("ready_low", {31'd0, bus_if.bus_ready}, 32'd0);
    check("ch0_o", gpio_o[31:0], 32'h12345678);
    check("ch0_oe", gpio_oe[31:0], 32'h0000FFFF);
    check("ch1_o", gpio_o[63:32], 32'h0000000C);
    check("ch1_oe", gpio_oe[63:32], 32'h00000000);

    // Rising edge on ch1 bit0, sampled by back-to-back PEND reads
    acc(1'b1, 8'h2C, 32'h1);
    acc(1'b1, 8'h30, 32'h1);
    gpio_i[32] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus_if.bus_en   = 1'b1;
      bus_if.bus_we   = 1'b0;
      bus_if.bus_addr = 8'h34;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rise_ready_%0d", k), {31'd0, bus_if.bus_ready}, 32'd1);
      check($sformatf("rise_pend_%0d", k), bus_if.bus_rdata, (k >= 4) ? 32'd1 : 32'd0);
      check($sformatf("rise_irq_%0d", k), {31'd0, irq}, (k >= 4) ? 32'd1 : 32'd0);
    end
    bus_if.bus_en = 1'b0;

    // Falling edge sets PEND in the same edge as a W1C: set wins
    gpio_i[32] = 1'b0;
    idle(2);
    acc(1'b1, 8'h34, 32'h1);
    check("race_irq_a", {31'd0, irq}, 32'd1);
    idle(1);
    check("race_irq_b", {31'd0, irq}, 32'd1);
    acc(1'b0, 8'h34, 32'h0);
    check("race_pend", bus_if.bus_rdata, 32'd1);

    // Plain W1C: irq low two cycles after the write
    acc(1'b1, 8'h34, 32'h1);
    check("w1c_irq_a", {31'd0, irq}, 32'd1);
    idle(1);
    check("w1c_irq_b", {31'd0, irq}, 32'd0);
    acc(1'b0, 8'h34, 32'h0);
    check("w1c_pend", bus_if.bus_rdata, 32'd0);

    // New rise, then clearing RISE_EN leaves PEND and irq set
    gpio_i[32] = 1'b1;
    idle(5);
    check("rise2_irq", {31'd0, irq}, 32'd1);
    acc(1'b1, 8'h2C, 32'h0);
    idle(2);
    check("en_clr_irq", {31'd0, irq}, 32'd1);

    // Reset in the middle of back-to-back reads
    bus_if.bus_en   = 1'b1;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_addr = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b_rdata_%0d", k), bus_if.bus_rdata, 32'h12345678);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_if.bus_en = 1'b0;
    check("mrst_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    check("mrst_irq", {31'd0, irq}, 32'd0);
    check("mrst_rdata", bus_if.bus_rdata, 32'd0);
    check("mrst_oe", gpio_oe[31:0] | gpio_oe[63:32], 32'd0);
    check("mrst_o", gpio_o[31:0] | gpio_o[63:32], 32'd0);

    zero_addrs = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h2C, 8'h30, 8'h34};
    for (int i = 0; i < 10; i++) begin
      acc(1'b0, zero_addrs[i], 32'h0);
      check($sformatf("post_rst_%0d", i), bus_if.bus_rdata, 32'd0);
    end
    idle(3);
    check("no_spurious_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter CHANNELS, default 2: number of GPIO channels (1..8).
REQ-002 Parameter WIDTH, default 32: pins per channel (1..32).
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth (>=2).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 bus_en  in  1  access request this cycle; one access per asserted cycle.
REQ-007 bus_we  in  1  1 = write, 0 = read.
REQ-008 bus_addr  in  8  byte address; channel c occupies offsets c*0x20 .. c*0x20+0x1C.
REQ-009 bus_wdata  in  32  write data.
REQ-010 bus_rdata  out  32  read data, valid while bus_ready = 1.
REQ-011 bus_ready  out  1  response strobe for the access of the previous cycle.
REQ-012 bus_error  out  1  qualified by bus_ready; access was invalid.
REQ-013 gpio_i  in  CHANNELS*WIDTH  pad inputs, asynchronous; channel c uses bits [c*WIDTH +: WIDTH].
REQ-014 gpio_o  out  CHANNELS*WIDTH  pad output values.
REQ-015 gpio_oe  out  CHANNELS*WIDTH  pad output enables; 1 = drive.
REQ-016 irq  out  1  level interrupt request to the core.

Function
REQ-017 Per-channel registers at word offsets: 0x00 OUT (RW), 0x04 DIR (RW, 1 = output), 0x08 IN (RO), 0x0C RISE_EN (RW), 0x10 FALL_EN (RW), 0x14 PEND (read; write-1-to-clear), 0x18 SET (WO, write-1 sets OUT bits), 0x1C CLR (WO, write-1 clears OUT bits).
REQ-018 Register bits above WIDTH read 0, ignore writes; SET/CLR read 0.
REQ-019 gpio_o = OUT and gpio_oe = DIR, combinationally from the registers.
REQ-020 Access fixed latency: bus_ready = 1 exactly one cycle after each cycle with bus_en = 1; back-to-back accesses are accepted every cycle.
REQ-021 Writes update the target register at the accepting clock edge; reads return register state as of the accepting cycle.
REQ-022 bus_error = 1 with bus_ready when channel index >= CHANNELS or bus_addr[1:0] != 0 or write to IN; such accesses have no side effects; bus_rdata = 0.
REQ-023 bus_rdata = 0 whenever bus_ready = 0.
REQ-024 Each gpio_i bit passes through SYNC_STAGES flops; IN reflects the last stage, for all pins regardless of DIR.
REQ-025 Edge detect compares last sync stage with a one-cycle-delayed copy; rising edge with RISE_EN bit set, or falling edge with FALL_EN bit set, sets the PEND bit at the next edge.
REQ-026 Pin change to PEND set: SYNC_STAGES+1 cycles; PEND to irq: 1 cycle (irq registered = OR of all PEND bits of all channels).
REQ-027 PEND write-1-to-clear and a new qualifying edge on the same bit in the same cycle: set wins (PEND stays 1).
REQ-028 Clearing RISE_EN/FALL_EN does not clear PEND; irq deasserts only when all PEND bits are 0.
REQ-029 Edges on pins whose DIR = 1 are detected identically (loopback via pad).

Reset
REQ-030 While reset = 1 at a clock edge: OUT, DIR, RISE_EN, FALL_EN, PEND, synchroniser and delay flops, irq, bus_ready, bus_error, bus_rdata all become 0; gpio_oe = 0 (all pins input).
REQ-031 A bus access in the cycle reset is asserted is discarded; bus_ready = 0 the following cycle.
REQ-032 First cycle after reset: no spurious edge (all enables are 0).

Verification
REQ-033 Write 0x04=0x0000FFFF, 0x00=0x12345678; read 0x00 -> bus_rdata 0x12345678, gpio_oe ch0 = 0x0000FFFF, gpio_o ch0 = 0x12345678.
REQ-034 Write SET 0x18=0x0000000F then CLR 0x1C=0x00000003 on OUT=0 -> read OUT = 0x0000000C.
REQ-035 RISE_EN ch1 (0x2C)=0x1; drive gpio_i bit WIDTH 0->1 at cycle t -> PEND ch1 bit0 = 1 at t+3, irq = 1 at t+4 (SYNC_STAGES=2); write 0x34=0x1 -> irq = 0 two cycles later.
REQ-036 Read 0x40 with CHANNELS=2, read 0x02, write 0x08 -> each bus_ready with bus_error = 1, rdata 0, no register change.
REQ-037 PEND W1C issued in the same cycle as a qualifying edge registers -> PEND remains 1, irq stays 1.
REQ-038 Assert reset mid-stream of back-to-back reads with irq = 1 -> next cycle irq = 0, bus_ready = 0, gpio_oe = 0, all registers read 0.
